// File: rtl/rom_is_tx.sv
// ---------------------------------------------------------------------------
// rom_is_tx -- instruction ROM transmitter
//
// Locks to the CTC 56-bit frame using the sync window (high T45..T54),
// shifts in an 8-bit ROM address from ia at T19..T26, fetches the 10-bit
// word at T27 and drives it LSB first onto the shared is line at T45..T54.
// Several instances share the is line; each one watches the resolved line
// (is_in) for ROM-select words and only the selected instance drives.
//
// Parameters
//   ROM_ID    3-bit chip number matched by a ROM-select word
//   ROM_INIT  image name for the 256x10 array (contents preloaded externally)
//
// Ports
//   cph2      in   system clock, all state on posedge
//   rst       in   synchronous reset, active-high
//   sync      in   CTC sync, high T45..T54 of each frame
//   ia        in   serial ROM address from CTC, LSB first
//   is_in     in   resolved shared is line, monitored for ROM-select
//   is_out    out  serial instruction bit, 0 when is_oe=0
//   is_oe     out  drive enable for is_out
//   active    out  this ROM is the selected ROM
//   locked    out  frame timing locked
//   sync_err  out  sticky: sync mismatch seen since reset
// ---------------------------------------------------------------------------
module rom_is_tx #(
    parameter logic [2:0] ROM_ID   = 3'd0,
    parameter string      ROM_INIT = "rom0.hex"
) (
    input  logic cph2,
    input  logic rst,
    input  logic sync,
    input  logic ia,
    input  logic is_in,
    output logic is_out,
    output logic is_oe,
    output logic active,
    output logic locked,
    output logic sync_err
);

    typedef enum logic {
        ST_UNSYNC = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [6:0] ia_sh_q, ia_sh_d;     // address bits 0..6 collected before T26
    logic [7:0] adr_q, adr_d;
    logic [9:0] sh_q, sh_d;           // is line capture for ROM-select decode
    logic [9:0] word_q;
    logic       sync_d_q;
    logic       full_q, full_d;       // a complete frame has been fetched since lock
    logic       active_q, active_d;
    logic       sync_err_q, sync_err_d;

    logic [9:0] mem [256];

    logic       in_win;
    logic       run_ok;
    logic       fetch_en;
    logic [5:0] bit_off;

    assign in_win   = (cnt_q >= 6'd45) && (cnt_q <= 6'd54);
    // RUN and the sync line agrees with where the counter says we are
    assign run_ok   = (state_q == ST_RUN) && (sync == in_win);
    assign fetch_en = run_ok && (cnt_q == 6'd27);
    assign bit_off  = cnt_q - 6'd45;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ia_sh_d    = ia_sh_q;
        adr_d      = adr_q;
        sh_d       = sh_q;
        full_d     = full_q;
        active_d   = active_q;
        sync_err_d = sync_err_q;

        case (state_q)
            ST_UNSYNC: begin
                // the rising-edge cycle is T45, so the counter resumes at 46;
                // the rest of this frame is partial and must not emit or decode
                if (sync && !sync_d_q) begin
                    state_d = ST_RUN;
                    cnt_d   = 6'd46;
                    full_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (!run_ok) begin
                    // counter holds; a fresh rising edge is needed to relock
                    state_d    = ST_UNSYNC;
                    sync_err_d = 1'b1;
                end else begin
                    cnt_d = (cnt_q == 6'd55) ? 6'd0 : cnt_q + 6'd1;
                    if ((cnt_q >= 6'd19) && (cnt_q <= 6'd25))
                        ia_sh_d = {ia, ia_sh_q[6:1]};
                    if (cnt_q == 6'd26)
                        adr_d = {ia, ia_sh_q};
                    if (cnt_q == 6'd27)
                        full_d = 1'b1;
                    if (in_win)
                        sh_d = {is_in, sh_q[9:1]};
                    // only a frame whose whole window was captured may select
                    if ((cnt_q == 6'd55) && full_q && (sh_q[6:0] == 7'b0010000))
                        active_d = (sh_q[9:7] == ROM_ID);
                end
            end
            default: state_d = ST_UNSYNC;
        endcase
    end

    always_ff @(posedge cph2) begin
        if (rst) begin
            state_q    <= ST_UNSYNC;
            cnt_q      <= 6'd0;
            ia_sh_q    <= 7'd0;
            adr_q      <= 8'd0;
            sh_q       <= 10'd0;
            sync_d_q   <= 1'b0;
            full_q     <= 1'b0;
            active_q   <= (ROM_ID == 3'd0);
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ia_sh_q    <= ia_sh_d;
            adr_q      <= adr_d;
            sh_q       <= sh_d;
            sync_d_q   <= sync;
            full_q     <= full_d;
            active_q   <= active_d;
            sync_err_q <= sync_err_d;
        end
    end

    // registered ROM read, one fetch per frame at T27
    always_ff @(posedge cph2) begin
        if (rst)
            word_q <= 10'd0;
        else if (fetch_en)
            word_q <= mem[adr_q];
    end

    assign is_oe    = (state_q == ST_RUN) && active_q && in_win && full_q;
    assign is_out   = is_oe && word_q[bit_off[3:0]];
    assign active   = active_q;
    assign locked   = (state_q == ST_RUN);
    assign sync_err = sync_err_q;

endmodule

// File: tb/tb_rom_is_tx.sv
// ---------------------------------------------------------------------------
// tb_rom_is_tx -- two transmitters (ROM_ID 0 and 3) on one shared is line,
// plus a bench-driven foreign contribution. Checked frame by frame against a
// frame-level model: lock state, selected ROM, ROM images and the OR-ed line.
// ---------------------------------------------------------------------------
module tb_rom_is_tx;

    logic cph2 = 1'b0;
    logic rst, sync, ia, ext_bit;
    logic is_in;
    logic is_out0, is_oe0, active0, locked0, sync_err0;
    logic is_out3, is_oe3, active3, locked3, sync_err3;

    always #5 cph2 = ~cph2;

    assign is_in = is_out0 | is_out3 | ext_bit;

    rom_is_tx #(.ROM_ID(3'd0), .ROM_INIT("")) u_rom0 (
        .cph2(cph2), .rst(rst), .sync(sync), .ia(ia), .is_in(is_in),
        .is_out(is_out0), .is_oe(is_oe0), .active(active0),
        .locked(locked0), .sync_err(sync_err0)
    );

    rom_is_tx #(.ROM_ID(3'd3), .ROM_INIT("")) u_rom3 (
        .cph2(cph2), .rst(rst), .sync(sync), .ia(ia), .is_in(is_in),
        .is_out(is_out3), .is_oe(is_oe3), .active(active3),
        .locked(locked3), .sync_err(sync_err3)
    );

    int n_vec = 0;
    int n_bad = 0;
    int fidx  = 0;

    // reference model state
    logic [9:0] rom0_m [256];
    logic [9:0] rom3_m [256];
    bit m_locked, m_act0, m_act3, m_err;

    typedef struct {
        logic [7:0] addr;
        logic [9:0] ext;
        bit         early;
        logic [9:0] exp_w0;
        int         exp_n0;
        logic [9:0] exp_w3;
        int         exp_n3;
        logic       exp_act0;
        logic       exp_act3;
        logic       exp_lock;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One 56-cycle CTC frame. Checks every cycle against the model, returns
    // the bits seen in the emission window and the is_oe counts.
    task automatic run_frame(input logic [7:0] addr, input logic [9:0] ext, input bit early_in,
                             output logic [9:0] got0, output logic [9:0] got3,
                             output int n0, output int n3);
        bit early, full, lockf, errf, win;
        logic [9:0] w0, w3, line;
        logic x_oe0, x_oe3, x_out0, x_out3, x_lock, x_err;
        early = early_in && m_locked;
        full  = m_locked && !early;
        lockf = !m_locked;
        errf  = early;
        w0 = rom0_m[addr];
        w3 = rom3_m[addr];
        got0 = '0; got3 = '0; n0 = 0; n3 = 0;
        for (int t = 0; t < 56; t++) begin
            @(negedge cph2);
            sync    = early ? (t >= 44 && t <= 54) : (t >= 45 && t <= 54);
            ia      = (t >= 19 && t <= 26) ? addr[t-19] : 1'($urandom);
            ext_bit = (t >= 45 && t <= 54) ? ext[t-45] : 1'($urandom);
            #1;
            win    = (t >= 45 && t <= 54);
            x_oe0  = full && m_act0 && win;
            x_oe3  = full && m_act3 && win;
            x_out0 = x_oe0 ? w0[t-45] : 1'b0;
            x_out3 = x_oe3 ? w3[t-45] : 1'b0;
            x_lock = lockf ? (t >= 46) : (errf ? (t <= 44) : 1'b1);
            x_err  = m_err || (errf && t >= 45);
            chk($sformatf("frame%0d t%0d {lock,err,act0,act3,oe0,out0,oe3,out3}", fidx, t),
                {24'd0, locked0, sync_err0, active0, active3, is_oe0, is_out0, is_oe3, is_out3},
                {24'd0, x_lock, x_err, m_act0, m_act3, x_oe0, x_out0, x_oe3, x_out3});
            if (win) begin
                got0[t-45] = is_out0;
                got3[t-45] = is_out3;
            end
            n0 += int'(is_oe0);
            n3 += int'(is_oe3);
        end
        @(posedge cph2);
        #1;
        if (lockf) m_locked = 1'b1;
        if (errf) begin
            m_locked = 1'b0;
            m_err    = 1'b1;
        end
        if (full) begin
            line = (m_act0 ? w0 : 10'd0) | (m_act3 ? w3 : 10'd0) | ext;
            if (line[6:0] == 7'h10) begin
                m_act0 = (line[9:7] == 3'd0);
                m_act3 = (line[9:7] == 3'd3);
            end
        end
        fidx++;
    endtask

    initial begin
        logic [9:0] g0, g3;
        int k0, k3;
        logic [2:0] ids [5];

        rst = 1'b1; sync = 1'b0; ia = 1'b0; ext_bit = 1'b0;
        ids[0] = 3'd0; ids[1] = 3'd3; ids[2] = 3'd0; ids[3] = 3'd3; ids[4] = 3'd5;

        for (int i = 0; i < 256; i++) begin
            rom0_m[i] = 10'($urandom);
            rom3_m[i] = 10'($urandom);
        end
        rom0_m[8'h5A] = 10'h2B6;
        rom0_m[8'h10] = 10'h000;
        rom3_m[8'h5A] = 10'h3C1;
        rom3_m[8'h22] = 10'h010;
        for (int i = 0; i < 256; i++) begin
            u_rom0.mem[i] = rom0_m[i];
            u_rom3.mem[i] = rom3_m[i];
        end

        //            addr   ext     early w0      n0  w3      n3  act0  act3  lock
        vecs[0] = '{8'h5A, 10'h000, 1'b0, 10'h2B6, 10, 10'h000, 0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{8'h10, 10'h190, 1'b0, 10'h000, 10, 10'h000, 0, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{8'h5A, 10'h000, 1'b0, 10'h000, 0, 10'h3C1, 10, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{8'h22, 10'h000, 1'b0, 10'h000, 0, 10'h010, 10, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{8'h5A, 10'h2A0, 1'b0, 10'h2B6, 10, 10'h000, 0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{8'h5A, 10'h000, 1'b1, 10'h000, 0, 10'h000, 0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h5A, 10'h000, 1'b0, 10'h000, 0, 10'h000, 0, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{8'h5A, 10'h000, 1'b0, 10'h2B6, 10, 10'h000, 0, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{8'h10, 10'h190, 1'b0, 10'h000, 10, 10'h000, 0, 1'b0, 1'b1, 1'b1};

        // reset held for two cycles
        repeat (2) @(negedge cph2);
        #1;
        chk("reset {oe0,oe3,lock0,lock3,err0,err3,act0,act3}",
            {24'd0, is_oe0, is_oe3, locked0, locked3, sync_err0, sync_err3, active0, active3},
            {24'd0, 8'b0000_0010});
        @(negedge cph2);
        rst = 1'b0;

        // ia toggling while unlocked must not reach the address register
        for (int t = 0; t < 20; t++) begin
            @(negedge cph2);
            ia = t[0];
            #1;
            chk($sformatf("unsync t%0d {lock0,oe0,oe3}", t),
                {29'd0, locked0, is_oe0, is_oe3}, 32'd0);
        end
        chk("unsync adr0", {24'd0, u_rom0.adr_q}, 32'd0);
        chk("unsync adr3", {24'd0, u_rom3.adr_q}, 32'd0);

        m_locked = 1'b0; m_act0 = 1'b1; m_act3 = 1'b0; m_err = 1'b0;

        // lock-acquisition frame: partial, nothing emitted
        run_frame(8'h00, 10'h000, 1'b0, g0, g3, k0, k3);
        chk("lockframe oe count", k0 + k3, 0);

        for (int v = 0; v < 9; v++) begin
            run_frame(vecs[v].addr, vecs[v].ext, vecs[v].early, g0, g3, k0, k3);
            chk($sformatf("vec%0d word0", v), {22'd0, g0}, {22'd0, vecs[v].exp_w0});
            chk($sformatf("vec%0d oe0 count", v), k0, vecs[v].exp_n0);
            chk($sformatf("vec%0d word3", v), {22'd0, g3}, {22'd0, vecs[v].exp_w3});
            chk($sformatf("vec%0d oe3 count", v), k3, vecs[v].exp_n3);
            chk($sformatf("vec%0d {act0,act3,lock0}", v),
                {29'd0, active0, active3, locked0},
                {29'd0, vecs[v].exp_act0, vecs[v].exp_act3, vecs[v].exp_lock});
        end

        // reset in the middle of ROM 3's emission window
        for (int t = 0; t < 50; t++) begin
            @(negedge cph2);
            sync = (t >= 45);
            ia   = 1'($urandom);
        end
        @(negedge cph2);
        rst = 1'b1;
        #1;
        chk("midreset T50 oe3 before", {31'd0, is_oe3}, 32'd1);
        @(negedge cph2);
        rst  = 1'b0;
        sync = 1'b0;
        #1;
        chk("midreset {oe0,oe3,lock3,act0,act3,err3}",
            {26'd0, is_oe0, is_oe3, locked3, active0, active3, sync_err3},
            {26'd0, 6'b000100});
        m_locked = 1'b0; m_act0 = 1'b1; m_act3 = 1'b0; m_err = 1'b0;

        // randomized frames against the model
        for (int f = 0; f < 60; f++) begin
            logic [9:0] e;
            bit er;
            if ($urandom_range(0, 2) == 0)
                e = {ids[$urandom_range(0, 4)], 7'h10};
            else
                e = 10'($urandom);
            er = ($urandom_range(0, 7) == 0);
            run_frame(8'($urandom), e, er, g0, g3, k0, k3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
